// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin sharing of one header inserter among NUM_SRC sources.
// Ports: s_hdr_* per-source header offers (valid/data/keep/byte_cnt, ready back);
//        s_* per-source packet beats (valid/data/keep/last, ready back);
//        *_insert / *_in drive the inserter's header and data ports from the granted source;
//        grant_id current or last grant, busy while a grant is open, pkt_done/pkt_src packet completion pulse.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              s_hdr_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_hdr_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_hdr_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_hdr_byte_cnt,
  output logic [NUM_SRC-1:0]              s_hdr_ready,
  input  logic [NUM_SRC-1:0]              s_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep,
  input  logic [NUM_SRC-1:0]              s_last,
  output logic [NUM_SRC-1:0]              s_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  output logic                            valid_in,
  output logic [DATA_WD-1:0]              data_in,
  output logic [DATA_BYTE_WD-1:0]         keep_in,
  output logic                            last_in,
  input  logic                            ready_in,
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic                            pkt_done,
  output logic [SRC_WD-1:0]               pkt_src
);
  typedef enum logic [1:0] {IDLE, HDR, PKT} state_t;
  state_t state, state_n;
  logic [SRC_WD-1:0] ptr, pick;
  logic hdr_hs, done;
  // Lowest requester above ptr wins; if none, lowest requester at or below ptr (wrap-around).
  always_comb begin
    pick = ptr;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (s_hdr_valid[i] && SRC_WD'(i) <= ptr) pick = SRC_WD'(i);
    for (int i = NUM_SRC - 1; i >= 0; i--) if (s_hdr_valid[i] && SRC_WD'(i) > ptr) pick = SRC_WD'(i);
  end
  assign busy            = state != IDLE;
  assign data_insert     = s_hdr_data[grant_id*DATA_WD +: DATA_WD];
  assign keep_insert     = s_hdr_keep[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign byte_insert_cnt = s_hdr_byte_cnt[grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];
  assign valid_insert    = state == HDR && s_hdr_valid[grant_id];
  assign s_hdr_ready     = (state == HDR && ready_insert) ? NUM_SRC'(1) << grant_id : '0;
  assign data_in         = s_data[grant_id*DATA_WD +: DATA_WD];
  assign keep_in         = s_keep[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign last_in         = s_last[grant_id];
  assign valid_in        = state == PKT && s_valid[grant_id];
  assign s_ready         = (state == PKT && ready_in) ? NUM_SRC'(1) << grant_id : '0;
  assign hdr_hs          = valid_insert && ready_insert;
  assign done            = valid_in && ready_in && last_in;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (|s_hdr_valid ? HDR : IDLE) :
              state == HDR  ? (hdr_hs ? PKT : HDR) :
                              (done ? IDLE : PKT);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      ptr      <= SRC_WD'(NUM_SRC - 1);
      pkt_done <= 1'b0;
      pkt_src  <= '0;
    end else begin
      state    <= state_n;
      pkt_done <= done;
      if (done) pkt_src <= grant_id;
      if (state == IDLE && |s_hdr_valid) begin
        grant_id <= pick;
        ptr      <= pick;
      end
    end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb_axi_stream_header_arbiter: randomized and directed check of the arbiter against a transaction-level model.
module tb_axi_stream_header_arbiter;
  localparam int NS = 4, DW = 32, KW = 4, CW = 2, SW = 2;
  logic clk = 0, rst = 1;
  logic [NS-1:0] s_hdr_valid = '0, s_valid = '0, s_last = '0, s_hdr_ready, s_ready;
  logic [NS*DW-1:0] s_hdr_data = '0, s_data = '0;
  logic [NS*KW-1:0] s_hdr_keep = '0, s_keep = '0;
  logic [NS*CW-1:0] s_hdr_byte_cnt = '0;
  logic valid_insert, valid_in, last_in, busy, pkt_done;
  logic ready_insert = 1, ready_in = 1;
  logic [DW-1:0] data_insert, data_in;
  logic [KW-1:0] keep_insert, keep_in;
  logic [CW-1:0] byte_insert_cnt;
  logic [SW-1:0] grant_id, pkt_src;
  int n_tests = 0, n_fail = 0;
  int pq[NS][$];
  int left[NS];
  logic [NS-1:0] act = '0, hs_h = '0, hs_d = '0, e_hr, e_r;
  int start_p = 100, val_p = 100;
  bit rnd = 0, chk_en = 0, busy_q = 0, m_done = 0, found;
  int m_own = 0, m_ph = 0, m_ptr = NS - 1, m_src = 0;
  int g_log[$], d_log[$], ex[$];

  axi_stream_header_arbiter dut (
    .clk(clk), .rst(rst),
    .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep),
    .s_hdr_byte_cnt(s_hdr_byte_cnt), .s_hdr_ready(s_hdr_ready),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done), .pkt_src(pkt_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    chk({nm, " count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(nm, 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    rst = 1;
    cyc(1);
    rst = 0;
  endtask

  function automatic bit pending();
    pending = act != 0 || m_ph != 0;
    for (int i = 0; i < NS; i++) if (pq[i].size() > 0) pending = 1;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cyc(1);
      n++;
    end
    chk("drain timeout", 64'(n < budget), 64'(1));
    cyc(2);
  endtask

  // Source behaviour: hold header/beat until accepted, then advance; beats may be offered early.
  task automatic drive();
    if (rst) begin
      s_hdr_valid = '0;
      s_valid = '0;
      act = '0;
      for (int i = 0; i < NS; i++) begin
        pq[i].delete();
        left[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NS; i++) begin
      if (hs_h[i]) s_hdr_valid[i] = 0;
      if (hs_d[i]) begin
        s_valid[i] = 0;
        left[i]--;
        if (left[i] == 0) act[i] = 0;
      end
      if (!act[i] && pq[i].size() > 0 && $urandom_range(99) < start_p) begin
        left[i] = pq[i].pop_front();
        act[i] = 1;
        s_hdr_valid[i] = 1;
        s_hdr_data[i*DW +: DW] = $urandom;
        s_hdr_keep[i*KW +: KW] = KW'($urandom);
        s_hdr_byte_cnt[i*CW +: CW] = CW'($urandom);
      end
      if (act[i] && !s_valid[i] && $urandom_range(99) < val_p) begin
        s_valid[i] = 1;
        s_data[i*DW +: DW] = $urandom;
        s_keep[i*KW +: KW] = KW'($urandom);
        s_last[i] = left[i] == 1;
      end
    end
    if (rnd) begin
      ready_insert = $urandom_range(3) != 0;
      ready_in = $urandom_range(3) != 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    drive();
  end

  // Model: one owner at a time, phases 0 none / 1 header pending / 2 packet in flight.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      e_hr = '0;
      e_r = '0;
      if (m_ph == 1 && ready_insert) e_hr[m_own] = 1;
      if (m_ph == 2 && ready_in) e_r[m_own] = 1;
      chk("busy", 64'(busy), 64'(m_ph != 0));
      if (m_ph != 0) chk("grant_id", 64'(grant_id), 64'(m_own));
      chk("s_hdr_ready", 64'(s_hdr_ready), 64'(e_hr));
      chk("s_ready", 64'(s_ready), 64'(e_r));
      chk("valid_insert", 64'(valid_insert), 64'(m_ph == 1 && s_hdr_valid[m_own]));
      chk("valid_in", 64'(valid_in), 64'(m_ph == 2 && s_valid[m_own]));
      if (m_ph == 1) begin
        chk("data_insert", 64'(data_insert), 64'(s_hdr_data[m_own*DW +: DW]));
        chk("keep_insert", 64'(keep_insert), 64'(s_hdr_keep[m_own*KW +: KW]));
        chk("byte_insert_cnt", 64'(byte_insert_cnt), 64'(s_hdr_byte_cnt[m_own*CW +: CW]));
      end
      if (m_ph == 2 && s_valid[m_own]) begin
        chk("data_in", 64'(data_in), 64'(s_data[m_own*DW +: DW]));
        chk("keep_in", 64'(keep_in), 64'(s_keep[m_own*KW +: KW]));
        chk("last_in", 64'(last_in), 64'(s_last[m_own]));
      end
      chk("pkt_done", 64'(pkt_done), 64'(m_done));
      if (m_done) chk("pkt_src", 64'(pkt_src), 64'(m_src));
      if (busy && !busy_q) g_log.push_back(int'(grant_id));
      if (pkt_done) d_log.push_back(int'(pkt_src));
      busy_q = busy;
    end
    hs_h = rst ? '0 : s_hdr_valid & s_hdr_ready;
    hs_d = rst ? '0 : s_valid & s_ready;
    if (rst) begin
      m_ph = 0;
      m_own = 0;
      m_ptr = NS - 1;
      m_done = 0;
    end else begin
      m_done = m_ph == 2 && s_valid[m_own] && ready_in && s_last[m_own];
      if (m_done) m_src = m_own;
      if (m_ph == 0 && s_hdr_valid != 0) begin
        found = 0;
        for (int k = 1; k <= NS; k++)
          if (!found && s_hdr_valid[(m_ptr + k) % NS]) begin
            found = 1;
            m_own = (m_ptr + k) % NS;
          end
        m_ptr = m_own;
        m_ph = 1;
      end else if (m_ph == 1 && s_hdr_valid[m_own] && ready_insert) m_ph = 2;
      else if (m_done) m_ph = 0;
    end
  end

  initial begin
    cyc(2);
    rst = 0;
    chk_en = 1;
    chk("reset grant_id", 64'(grant_id), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset pkt_done", 64'(pkt_done), 64'(0));
    chk("reset pkt_src", 64'(pkt_src), 64'(0));
    chk("reset readys", 64'({s_hdr_ready, s_ready}), 64'(0));
    chk("reset valids", 64'({valid_insert, valid_in}), 64'(0));
    // single request from source 2, 3-beat packet
    pq[2].push_back(3);
    cyc(2);
    chk("A valid_insert", 64'(valid_insert), 64'(1));
    chk("A grant_id", 64'(grant_id), 64'(2));
    wait_idle(200);
    chk("A busy", 64'(busy), 64'(0));
    ex = {2};
    chk_q("A grants", g_log, ex);
    chk_q("A dones", d_log, ex);
    // all sources requesting, 2-beat packets
    pulse_rst();
    g_log.delete();
    d_log.delete();
    pq[0].push_back(2); pq[0].push_back(2);
    pq[1].push_back(2); pq[1].push_back(2);
    pq[2].push_back(2); pq[3].push_back(2);
    wait_idle(300);
    ex = {0, 1, 2, 3, 0, 1};
    chk_q("B grants", g_log, ex);
    chk_q("B dones", d_log, ex);
    // ready_in stall mid-packet from source 1 while source 3 waits
    g_log.delete();
    d_log.delete();
    ready_in = 0;
    pq[1].push_back(3);
    cyc(4);
    pq[3].push_back(1);
    cyc(10);
    chk("C grant_id", 64'(grant_id), 64'(1));
    chk("C s_ready", 64'(s_ready), 64'(0));
    chk("C valid_in", 64'(valid_in), 64'(1));
    ready_in = 1;
    wait_idle(200);
    ex = {1, 3};
    chk_q("C grants", g_log, ex);
    // early beat from source 0 before header accepted
    g_log.delete();
    d_log.delete();
    ready_insert = 0;
    pq[0].push_back(2);
    cyc(7);
    chk("D s_ready", 64'(s_ready), 64'(0));
    chk("D valid_insert", 64'(valid_insert), 64'(1));
    chk("D s_valid held", 64'(s_valid[0]), 64'(1));
    ready_insert = 1;
    wait_idle(200);
    ex = {0};
    chk_q("D dones", d_log, ex);
    // reset while source 2 is mid-packet
    g_log.delete();
    d_log.delete();
    ready_in = 0;
    pq[2].push_back(5);
    cyc(6);
    chk("E grant_id", 64'(grant_id), 64'(2));
    pulse_rst();
    chk("E busy", 64'(busy), 64'(0));
    chk("E readys", 64'({s_hdr_ready, s_ready}), 64'(0));
    chk("E valids", 64'({valid_insert, valid_in}), 64'(0));
    chk("E pkt_done", 64'(pkt_done), 64'(0));
    ready_in = 1;
    pq[2].push_back(1);
    wait_idle(200);
    ex = {2, 2};
    chk_q("E grants", g_log, ex);
    ex = {2};
    chk_q("E dones", d_log, ex);
    // back-to-back single-beat packets from sources 1 and 3
    pulse_rst();
    g_log.delete();
    d_log.delete();
    pq[1].push_back(1);
    pq[3].push_back(1);
    wait_idle(200);
    ex = {1, 3};
    chk_q("F dones", d_log, ex);
    // randomized traffic, backpressure and occasional reset
    rnd = 1;
    start_p = 30;
    val_p = 60;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(2) == 0) begin
        int s = $urandom_range(NS - 1);
        if (pq[s].size() < 2) pq[s].push_back($urandom_range(1, 4));
      end
      if ($urandom_range(599) == 0) pulse_rst();
      else cyc(1);
    end
    rnd = 0;
    ready_insert = 1;
    ready_in = 1;
    wait_idle(1000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_stream_header_arbiter.md
Name: axi_stream_header_arbiter

Overview:
- Shares one axi_stream_insert_header instance among NUM_SRC sources.
- Each source offers one header (data, keep, byte count) plus one packet stream.
- The arbiter grants sources round-robin and drives the inserter's header port and data port from the granted source.
- The grant is held until that source's last packet beat is accepted. Packets are therefore never interleaved.

Parameters:
- DATA_WD, 32, data bus width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the header byte count
- NUM_SRC, 4, number of sources (2..16)
- SRC_WD, $clog2(NUM_SRC), width of the grant index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_hdr_valid  in  NUM_SRC  header valid per source
- s_hdr_data  in  NUM_SRC*DATA_WD  headers; source i at [i*DATA_WD +: DATA_WD]
- s_hdr_keep  in  NUM_SRC*DATA_BYTE_WD  header keep per source
- s_hdr_byte_cnt  in  NUM_SRC*BYTE_CNT_WD  header byte count per source
- s_hdr_ready  out  NUM_SRC  header accepted
- s_valid  in  NUM_SRC  packet beat valid per source
- s_data  in  NUM_SRC*DATA_WD  packet data
- s_keep  in  NUM_SRC*DATA_BYTE_WD  packet keep
- s_last  in  NUM_SRC  last beat of packet
- s_ready  out  NUM_SRC  packet beat accepted
- valid_insert  out  1  to inserter
- data_insert  out  DATA_WD  to inserter
- keep_insert  out  DATA_BYTE_WD  to inserter
- byte_insert_cnt  out  BYTE_CNT_WD  to inserter
- ready_insert  in  1  from inserter
- valid_in  out  1  to inserter
- data_in  out  DATA_WD  to inserter
- keep_in  out  DATA_BYTE_WD  to inserter
- last_in  out  1  to inserter
- ready_in  in  1  from inserter
- grant_id  out  SRC_WD  current or last granted source
- busy  out  1  high in HDR or PKT state
- pkt_done  out  1  one-cycle pulse after a packet completes
- pkt_src  out  SRC_WD  source of the completed packet; valid while pkt_done is high

Behaviour:
- State machine: IDLE, HDR, PKT. State, grant_id, the round-robin pointer, pkt_done and pkt_src are registers. All other outputs are combinational from registered state and grant, plus the granted source's inputs.
- Reset (synchronous, takes effect at the edge where rst=1):
  - state=IDLE, grant_id=0, pointer=NUM_SRC-1 (so source 0 has first priority)
  - pkt_done=0, pkt_src=0
  - All valid and ready outputs read 0 in the cycle after that edge.
- Reset mid-packet aborts the transfer; no pkt_done is issued. Sources are expected to restart.
- IDLE:
  - All s_hdr_ready, s_ready, valid_insert and valid_in are 0.
  - If any s_hdr_valid is high, grant the first requesting source searching from pointer+1 upward, wrapping modulo NUM_SRC.
  - Register grant_id, pointer=grant, then go to HDR.
  - Arbitration is decided only on s_hdr_valid; s_valid alone never requests.
- HDR:
  - valid_insert = s_hdr_valid[g], and header fields are muxed from source g.
  - s_hdr_ready[g] = ready_insert; all other s_hdr_ready are 0.
  - On the handshake (valid_insert && ready_insert), go to PKT.
- PKT:
  - valid_in, data_in, keep_in and last_in are muxed from source g.
  - s_ready[g] = ready_in; all other s_ready are 0.
  - On a handshake with s_last[g]=1, go to IDLE, and in the next cycle set pkt_done=1 and pkt_src=g.
- Latency:
  - Request to valid_insert is 1 cycle.
  - The header handshake can be followed by the first packet beat in the next cycle.
  - Last beat accepted to the next grant is 2 cycles (PKT, IDLE, HDR).
- Single-beat packet (s_last on the first beat): handled normally, PKT to IDLE after one handshake.
- Packet beats offered before the header is accepted are stalled (s_ready=0); they are not dropped.
- A source must hold s_hdr_valid and s_valid, with stable data, until accepted. The arbiter never re-arbitrates mid-grant.
- Non-granted sources see ready=0 in every state.
- ready_insert or ready_in held low indefinitely: the arbiter stays in its current state, the grant is held and no timeout occurs.
- All requesters active: each source is granted exactly once per NUM_SRC packets.
- Multiplexed outputs in IDLE carry source grant_id's fields with valid=0; the values are don't-care.

Test Plan:
- Reset then a single request: s_hdr_valid=4'b0100 → grant_id=2 and valid_insert=1 one cycle later; 3-beat packet with s_last on beat 3 → pkt_done=1, pkt_src=2 one cycle after the last handshake; busy=0.
- All four s_hdr_valid high continuously, each source sending 2-beat packets → grant order 0,1,2,3,0,1; valid_in never carries a non-granted source's data; s_ready is one-hot or zero.
- ready_in held 0 for 10 cycles mid-packet from source 1 while source 3 requests → grant stays 1, s_ready=0 throughout, and source 3 is granted only after source 1's last beat.
- Source 0 asserts s_valid 5 cycles before ready_insert rises → s_ready[0]=0 until the header handshake, and the first beat is delivered the cycle after.
- rst=1 for one cycle while in PKT for source 2 → next cycle state=IDLE, all valids/readys=0, pkt_done=0, and the next request from source 2 is granted fresh.
- Single-beat packets back-to-back from sources 1 and 3 → each produces exactly one pkt_done, with pkt_src=1 then 3.
